// File: rtl/nios_system_led_sequencer_if.sv
// Avalon-MM slave bundle for the LED sequencer: register select, strobes and the
// combinational read-data return path.
interface nios_system_led_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/nios_system_led_sequencer.sv
// Prescaled 4-bit LED pattern sequencer (static / blink / rotate / bounce) on an Avalon-MM slave.
// Optional wrap interrupt and CTRL[3] enable are built when LED_SEQ_IRQ_EN is defined.
module nios_system_led_sequencer (
    input  logic                              clk,
    input  logic                              reset,
    nios_system_led_sequencer_if.slave        bus,
    output logic [3:0]                        out_port
`ifdef LED_SEQ_IRQ_EN
    ,
    output logic                              irq
`endif
);

`ifdef LED_SEQ_IRQ_EN
    localparam int CTRL_W = 4;
`else
    localparam int CTRL_W = 3;
`endif

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_ROTATE = 2'd2;
    localparam logic [1:0] MODE_BOUNCE = 2'd3;

    localparam logic [1:0] ADDR_PATTERN = 2'd0;
    localparam logic [1:0] ADDR_CTRL    = 2'd1;
    localparam logic [1:0] ADDR_PERIOD  = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    logic [3:0]        pattern_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [15:0]       period_q;
    logic [15:0]       presc_q;
    logic [1:0]        step_cnt_q;
    logic              wrap_q;
    logic [3:0]        out_q;
    logic              dir_right_q;

    logic        wr_en, wr_pattern, wr_ctrl, wr_period, wr_status;
    logic        reload_wr, run, step, wrap_set;
    logic [1:0]  mode;
    logic [15:0] reload_val;
    logic [3:0]  load_pattern;
    logic [3:0]  step_out;
    logic        step_dir_right;
    logic        unused_wdata;

    assign wr_en      = bus.chipselect & ~bus.write_n;
    assign wr_pattern = wr_en && (bus.address == ADDR_PATTERN);
    assign wr_ctrl    = wr_en && (bus.address == ADDR_CTRL);
    assign wr_period  = wr_en && (bus.address == ADDR_PERIOD);
    assign wr_status  = wr_en && (bus.address == ADDR_STATUS);

    assign run  = ctrl_q[2];
    assign mode = ctrl_q[1:0];

    // PERIOD=0 reloads to 0 as well, so it steps every cycle exactly like PERIOD=1.
    assign reload_val = (period_q == 16'd0) ? 16'd0 : period_q - 16'd1;

    // A PATTERN/CTRL write restarts the sequence and swallows a coincident step.
    assign reload_wr    = wr_pattern | wr_ctrl;
    assign step         = run && (presc_q == 16'd0) && !reload_wr;
    assign wrap_set     = step && (step_cnt_q == 2'd3);
    assign load_pattern = wr_pattern ? bus.writedata[3:0] : pattern_q;

    assign unused_wdata = ^bus.writedata[31:16];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        step_out       = out_q;
        step_dir_right = dir_right_q;
        unique case (mode)
            MODE_STATIC: step_out = out_q;
            MODE_BLINK:  step_out = (out_q != 4'b0000) ? 4'b0000 : pattern_q;
            MODE_ROTATE: step_out = {out_q[2:0], out_q[3]};
            MODE_BOUNCE: begin
                if (out_q != 4'b0000) begin
                    if (!dir_right_q) begin
                        if (out_q[3]) begin
                            step_dir_right = 1'b1;
                            step_out       = {1'b0, out_q[3:1]};
                        end else begin
                            step_out = {out_q[2:0], 1'b0};
                        end
                    end else begin
                        if (out_q[0]) begin
                            step_dir_right = 1'b0;
                            step_out       = {out_q[2:0], 1'b0};
                        end else begin
                            step_out = {1'b0, out_q[3:1]};
                        end
                    end
                end
            end
            default: step_out = out_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q   <= '0;
            ctrl_q      <= '0;
            period_q    <= '0;
            presc_q     <= '0;
            step_cnt_q  <= '0;
            wrap_q      <= 1'b0;
            out_q       <= '0;
            dir_right_q <= 1'b0;
        end else begin
            if (wr_pattern) pattern_q <= bus.writedata[3:0];
            if (wr_ctrl)    ctrl_q    <= bus.writedata[CTRL_W-1:0];
            if (wr_period)  period_q  <= bus.writedata[15:0];

            if (reload_wr) begin
                out_q       <= load_pattern;
                presc_q     <= reload_val;
                step_cnt_q  <= 2'd0;
                dir_right_q <= 1'b0;
            end else if (run) begin
                if (step) begin
                    presc_q     <= reload_val;
                    out_q       <= step_out;
                    dir_right_q <= step_dir_right;
                    step_cnt_q  <= step_cnt_q + 2'd1;
                end else begin
                    presc_q <= presc_q - 16'd1;
                end
            end

            // Set wins over a same-cycle W1C so a wrap is never lost.
            if (wrap_set)
                wrap_q <= 1'b1;
            else if (wr_status && bus.writedata[1])
                wrap_q <= 1'b0;
        end
    end

    always_comb begin
        bus.readdata = 32'd0;
        unique case (bus.address)
            ADDR_PATTERN: bus.readdata = {28'd0, out_q};
            ADDR_CTRL:    bus.readdata = {{(32 - CTRL_W){1'b0}}, ctrl_q};
            ADDR_PERIOD:  bus.readdata = {16'd0, period_q};
            ADDR_STATUS:  bus.readdata = {30'd0, wrap_q, run};
            default:      bus.readdata = 32'd0;
        endcase
    end

    assign out_port = out_q;

`ifdef LED_SEQ_IRQ_EN
    assign irq = wrap_q & ctrl_q[3];
`endif

endmodule

// File: tb/tb_nios_system_led_sequencer.sv
// Directed self-checking bench for nios_system_led_sequencer; irq checks are built only
// when LED_SEQ_IRQ_EN is defined, otherwise CTRL[3] is checked to read back as 0.
`timescale 1ns/100ps
module tb_nios_system_led_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] out_port;
`ifdef LED_SEQ_IRQ_EN
    logic       irq;
`endif

    int total = 0;
    int bad   = 0;

    nios_system_led_sequencer_if bus ();

    nios_system_led_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .out_port (out_port)
`ifdef LED_SEQ_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic wait_edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Write lands on the next rising edge; returns 1 ns after that edge.
    task automatic write_reg(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic read_reg(input logic [1:0] addr, output logic [31:0] data);
        bus.address = addr;
        #1;
        data = bus.readdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        wait_edges(1);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        do_reset();
        total++;
        if (out_port !== 4'b0000) begin
            bad++;
            $display("FAIL reset_out_port got=%b exp=0000", out_port);
        end
        for (int a = 0; a < 4; a++) begin
            read_reg(a[1:0], rd);
            total++;
            if (rd !== 32'd0) begin
                bad++;
                $display("FAIL reset_readdata addr=%0d got=%h exp=00000000", a, rd);
            end
        end
    endtask

    task automatic test_rotate();
        logic [3:0]  exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [31:0] rd;
        do_reset();
        write_reg(2'd0, 32'h1);
        write_reg(2'd2, 32'd3);
        write_reg(2'd1, 32'b110);
        total++;
        if (out_port !== exp_seq[0]) begin
            bad++;
            $display("FAIL rotate_load got=%b exp=%b", out_port, exp_seq[0]);
        end
        for (int k = 1; k < 5; k++) begin
            wait_edges(2);
            total++;
            if (out_port !== exp_seq[k-1]) begin
                bad++;
                $display("FAIL rotate_hold step%0d got=%b exp=%b", k, out_port, exp_seq[k-1]);
            end
            wait_edges(1);
            total++;
            if (out_port !== exp_seq[k]) begin
                bad++;
                $display("FAIL rotate_step step%0d got=%b exp=%b", k, out_port, exp_seq[k]);
            end
            if (k == 3) begin
                read_reg(2'd3, rd);
                total++;
                if (rd[1] !== 1'b0) begin
                    bad++;
                    $display("FAIL rotate_wrap_early got=%b exp=0", rd[1]);
                end
            end
        end
        read_reg(2'd3, rd);
        total++;
        if (rd !== 32'h3) begin
            bad++;
            $display("FAIL rotate_status got=%h exp=00000003", rd);
        end
    endtask

    task automatic test_period_zero();
        do_reset();
        write_reg(2'd0, 32'h1);
        write_reg(2'd2, 32'd0);
        write_reg(2'd1, 32'b110);
        wait_edges(1);
        total++;
        if (out_port !== 4'b0010) begin
            bad++;
            $display("FAIL period0_step1 got=%b exp=0010", out_port);
        end
        wait_edges(1);
        total++;
        if (out_port !== 4'b0100) begin
            bad++;
            $display("FAIL period0_step2 got=%b exp=0100", out_port);
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp_seq [5] = '{4'b0110, 4'b1100, 4'b0110, 4'b0011, 4'b0110};
        do_reset();
        write_reg(2'd0, 32'h3);
        write_reg(2'd2, 32'd1);
        write_reg(2'd1, 32'b111);
        total++;
        if (out_port !== 4'b0011) begin
            bad++;
            $display("FAIL bounce_load got=%b exp=0011", out_port);
        end
        for (int k = 0; k < 5; k++) begin
            wait_edges(1);
            total++;
            if (out_port !== exp_seq[k]) begin
                bad++;
                $display("FAIL bounce_step%0d got=%b exp=%b", k + 1, out_port, exp_seq[k]);
            end
        end
    endtask

    task automatic test_blink_and_reload();
        logic [3:0] exp_seq [4] = '{4'b1010, 4'b0000, 4'b0000, 4'b1010};
        do_reset();
        write_reg(2'd0, 32'hA);
        write_reg(2'd2, 32'd2);
        write_reg(2'd1, 32'b101);
        for (int k = 0; k < 4; k++) begin
            wait_edges(1);
            total++;
            if (out_port !== exp_seq[k]) begin
                bad++;
                $display("FAIL blink_edge%0d got=%b exp=%b", k + 1, out_port, exp_seq[k]);
            end
        end
        // Next write edge coincides with a step; the write must win.
        wait_edges(1);
        write_reg(2'd0, 32'h5);
        total++;
        if (out_port !== 4'b0101) begin
            bad++;
            $display("FAIL blink_reload got=%b exp=0101", out_port);
        end
        wait_edges(1);
        total++;
        if (out_port !== 4'b0101) begin
            bad++;
            $display("FAIL blink_reload_hold got=%b exp=0101", out_port);
        end
        wait_edges(1);
        total++;
        if (out_port !== 4'b0000) begin
            bad++;
            $display("FAIL blink_after_reload got=%b exp=0000", out_port);
        end
    endtask

    task automatic test_period_write();
        do_reset();
        write_reg(2'd0, 32'h1);
        write_reg(2'd2, 32'd4);
        write_reg(2'd1, 32'b110);
        write_reg(2'd2, 32'd2);
        wait_edges(2);
        total++;
        if (out_port !== 4'b0001) begin
            bad++;
            $display("FAIL period_wr_hold got=%b exp=0001", out_port);
        end
        wait_edges(1);
        total++;
        if (out_port !== 4'b0010) begin
            bad++;
            $display("FAIL period_wr_old_spacing got=%b exp=0010", out_port);
        end
        wait_edges(1);
        total++;
        if (out_port !== 4'b0010) begin
            bad++;
            $display("FAIL period_wr_new_hold got=%b exp=0010", out_port);
        end
        wait_edges(1);
        total++;
        if (out_port !== 4'b0100) begin
            bad++;
            $display("FAIL period_wr_new_spacing got=%b exp=0100", out_port);
        end
    endtask

    task automatic test_wrap_w1c();
        logic [31:0] rd;
`ifdef LED_SEQ_IRQ_EN
        logic [31:0] ctrl_exp = 32'hA;
`else
        logic [31:0] ctrl_exp = 32'h2;
`endif
        do_reset();
        write_reg(2'd0, 32'h1);
        write_reg(2'd2, 32'd1);
        write_reg(2'd1, 32'b1110);
        wait_edges(3);
        read_reg(2'd3, rd);
        total++;
        if (rd[1] !== 1'b0) begin
            bad++;
            $display("FAIL wrap_before got=%b exp=0", rd[1]);
        end
        wait_edges(1);
        read_reg(2'd3, rd);
        total++;
        if (rd !== 32'h3) begin
            bad++;
            $display("FAIL wrap_set_status got=%h exp=00000003", rd);
        end
        write_reg(2'd1, 32'b1010);
        read_reg(2'd1, rd);
        total++;
        if (rd !== ctrl_exp) begin
            bad++;
            $display("FAIL ctrl_readback got=%h exp=%h", rd, ctrl_exp);
        end
        read_reg(2'd3, rd);
        total++;
        if (rd !== 32'h2) begin
            bad++;
            $display("FAIL wrap_kept_stopped got=%h exp=00000002", rd);
        end
`ifdef LED_SEQ_IRQ_EN
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_set got=%b exp=1", irq);
        end
`endif
        wait_edges(3);
        total++;
        if (out_port !== 4'b0001) begin
            bad++;
            $display("FAIL run_off_hold got=%b exp=0001", out_port);
        end
        write_reg(2'd3, 32'h2);
        read_reg(2'd3, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL w1c_clear got=%h exp=00000000", rd);
        end
`ifdef LED_SEQ_IRQ_EN
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_clear got=%b exp=0", irq);
        end
`endif
        // Restart and land the W1C exactly on the wrapping step.
        write_reg(2'd1, 32'b1110);
        wait_edges(3);
        write_reg(2'd3, 32'h2);
        read_reg(2'd3, rd);
        total++;
        if (rd[1] !== 1'b1) begin
            bad++;
            $display("FAIL w1c_coincident got=%b exp=1", rd[1]);
        end
`ifdef LED_SEQ_IRQ_EN
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_coincident got=%b exp=1", irq);
        end
`endif
    endtask

    task automatic test_mid_reset();
        logic [31:0] rd;
        do_reset();
        write_reg(2'd0, 32'h1);
        write_reg(2'd2, 32'd3);
        write_reg(2'd1, 32'b110);
        wait_edges(6);
        total++;
        if (out_port !== 4'b0100) begin
            bad++;
            $display("FAIL midrst_pre got=%b exp=0100", out_port);
        end
        reset = 1'b1;
        #1;
        total++;
        if (out_port !== 4'b0000) begin
            bad++;
            $display("FAIL midrst_async got=%b exp=0000", out_port);
        end
        #12;
        reset = 1'b0;
        wait_edges(10);
        total++;
        if (out_port !== 4'b0000) begin
            bad++;
            $display("FAIL midrst_idle got=%b exp=0000", out_port);
        end
        read_reg(2'd1, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL midrst_ctrl got=%h exp=00000000", rd);
        end
    endtask

    initial begin
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
        #12;
        reset = 1'b0;
        test_reset();
        test_rotate();
        test_period_zero();
        test_bounce();
        test_blink_and_reload();
        test_period_write();
        test_wrap_w1c();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1, "bench timeout");
    end

endmodule
